ext_accum_seq: RTL and testbench

- Sequential multi-operand adder that accepts a stream of IN_W-bit operands and extends each to SUM_W bits (zero- or sign-extension, by parameter).
- Accumulates the extended operands over a group of up to BEATS operands, then presents the sum with a sticky overflow flag.
- Generalises the single two-operand, context-widened add to N operands, with selectable signedness and selectable wrap/saturate handling.
- Sits in arithmetic datapaths between a valid/ready producer and consumer.

---
 rtl/ext_accum_pkg.sv | 44 ++++
 rtl/ext_accum_seq_add.sv | 51 +++++
 rtl/ext_accum_seq.sv | 143 ++++++++++++++
 tb/tb_ext_accum_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ext_accum_pkg.sv
// ============================================================================
//  Module   : ext_accum_pkg
//  Purpose  : Shared state encoding and width/extension helpers for the
//             ext_accum_seq multi-operand accumulator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ext_accum_pkg;

  // Helpers work on a fixed wide vector; callers slice down to SUM_W.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [MAX_W-1:0] ext_op(input logic [MAX_W-1:0] data,
                                              input int inW,
                                              input logic isSigned);
    logic [MAX_W-1:0] up;
    up = data << (MAX_W - inW);
    if (isSigned) return $signed(up) >>> (MAX_W - inW);
    return up >> (MAX_W - inW);
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int sumW, input logic isSigned);
    logic [MAX_W-1:0] ones;
    ones = {MAX_W{1'b1}} >> (MAX_W - sumW);
    if (isSigned) return ones >> 1;
    return ones;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int sumW, input logic isSigned);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    if (isSigned) return one << (sumW - 1);
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_accum_seq_add.sv
// ============================================================================
//  Module   : ext_add_ovf
//  Purpose  : Combinational SUM_W+1 bit add with overflow detection and
//             wrap or clamp selection of the next accumulator value.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_add_ovf
  import ext_accum_pkg::*;
#(
  parameter int SUM_W    = 17,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [SUM_W-1:0] acc,
  input  logic [SUM_W-1:0] ext,
  output logic [SUM_W:0]   raw,
  output logic             ovf,
  output logic [SUM_W-1:0] nextAcc
);

  localparam logic [MAX_W-1:0] c_satMaxW = sat_max(SUM_W, SIGNED != 0);
  localparam logic [MAX_W-1:0] c_satMinW = sat_min(SUM_W, SIGNED != 0);
  localparam logic [SUM_W-1:0] c_satMax  = c_satMaxW[SUM_W-1:0];
  localparam logic [SUM_W-1:0] c_satMin  = c_satMinW[SUM_W-1:0];

  assign raw = {1'b0, acc} + {1'b0, ext};

  generate
    if (SIGNED != 0) begin : g_signedOvf
      assign ovf = (acc[SUM_W-1] == ext[SUM_W-1]) && (raw[SUM_W-1] != acc[SUM_W-1]);
    end else begin : g_unsignedOvf
      assign ovf = raw[SUM_W];
    end
  endgenerate

  generate
    if (SATURATE != 0) begin : g_saturate
      // Clamp direction follows the operand sign; unsigned only ever overflows upward.
      logic [SUM_W-1:0] w_clamp;
      assign w_clamp = ((SIGNED != 0) && ext[SUM_W-1]) ? c_satMin : c_satMax;
      assign nextAcc = ovf ? w_clamp : raw[SUM_W-1:0];
    end else begin : g_wrap
      assign nextAcc = raw[SUM_W-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ext_accum_seq.sv
// ============================================================================
//  Module   : ext_accum_seq
//  Purpose  : Streams IN_W-bit operands, extends them to SUM_W and sums up to
//             BEATS of them per group, presenting sum, sticky overflow, count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_accum_seq
  import ext_accum_pkg::*;
#(
  parameter int IN_W     = 15,
  parameter int SUM_W    = 17,
  parameter int BEATS    = 4,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0,
  parameter int CNT_W    = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  generate
    if (SUM_W < IN_W) begin : g_badSumW
      $error("ext_accum_seq: SUM_W must be >= IN_W");
    end
    if (SUM_W > MAX_W) begin : g_badMaxW
      $error("ext_accum_seq: SUM_W exceeds helper width");
    end
    if (BEATS < 1) begin : g_badBeats
      $error("ext_accum_seq: BEATS must be >= 1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_one     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_lastIdx = CNT_W'(BEATS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [SUM_W-1:0] r_outSum;
  logic             r_outOvf;
  logic [CNT_W-1:0] r_outCount;

  logic [MAX_W-1:0] w_dataWide;
  logic [MAX_W-1:0] w_extWide;
  logic [SUM_W-1:0] w_ext;
  logic [SUM_W:0]   w_unusedRaw;
  logic             w_addOvf;
  logic [SUM_W-1:0] w_nextAcc;
  logic             w_accept;
  logic             w_groupEnd;
  logic             w_release;

  always_comb begin
    w_dataWide = '0;
    w_dataWide[IN_W-1:0] = in_data;
  end

  assign w_extWide = ext_op(w_dataWide, IN_W, SIGNED != 0);
  assign w_ext     = w_extWide[SUM_W-1:0];

  ext_add_ovf #(
    .SUM_W    (SUM_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_add (
    .acc     (r_acc),
    .ext     (w_ext),
    .raw     (w_unusedRaw),
    .ovf     (w_addOvf),
    .nextAcc (w_nextAcc)
  );

  // Handshakes derive from the state register only, keeping the FSM loop-free.
  assign w_accept   = in_valid && (r_state == ACC);
  assign w_groupEnd = w_accept && (in_last || (r_cnt == c_lastIdx));
  assign w_release  = out_ready && (r_state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (w_groupEnd) w_nextState = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = ACC;
      end
      default: w_nextState = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_outSum   <= '0;
      r_outOvf   <= 1'b0;
      r_outCount <= '0;
    end else if (w_accept) begin
      r_acc <= w_nextAcc;
      r_cnt <= r_cnt + c_one;
      r_ovf <= r_ovf | w_addOvf;
      if (w_groupEnd) begin
        r_outSum   <= w_nextAcc;
        r_outOvf   <= r_ovf | w_addOvf;
        r_outCount <= r_cnt + c_one;
      end
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign out_sum   = r_outSum;
  assign out_ovf   = r_outOvf;
  assign out_count = r_outCount;

endmodule

`default_nettype wire

// File: tb/tb_ext_accum_seq.sv
// ============================================================================
//  Module   : tb_ext_accum_seq
//  Purpose  : Directed self-checking bench for ext_accum_seq across unsigned
//             wrap/saturate and signed saturate configurations.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ext_accum_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Index 0: default unsigned wrap; 1: SUM16/BEATS3 wrap; 2: SUM16/BEATS3 sat;
  // 3: signed IN4/SUM6/BEATS5 sat.
  logic        inValid [4];
  logic        inLast  [4];
  logic        outReady[4];
  logic [14:0] inData  [4];

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        vld0, vld1, vld2, vld3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [16:0] sum0;
  logic [15:0] sum1, sum2;
  logic [5:0]  sum3;
  logic [2:0]  cnt0, cnt3;
  logic [1:0]  cnt1, cnt2;

  ext_accum_seq u0 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(rdy0), .in_data(inData[0]),
    .in_last(inLast[0]), .out_valid(vld0), .out_ready(outReady[0]), .out_sum(sum0),
    .out_ovf(ovf0), .out_count(cnt0));

  ext_accum_seq #(.IN_W(15), .SUM_W(16), .BEATS(3), .SIGNED(0), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(rdy1), .in_data(inData[1]),
    .in_last(inLast[1]), .out_valid(vld1), .out_ready(outReady[1]), .out_sum(sum1),
    .out_ovf(ovf1), .out_count(cnt1));

  ext_accum_seq #(.IN_W(15), .SUM_W(16), .BEATS(3), .SIGNED(0), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(rdy2), .in_data(inData[2]),
    .in_last(inLast[2]), .out_valid(vld2), .out_ready(outReady[2]), .out_sum(sum2),
    .out_ovf(ovf2), .out_count(cnt2));

  ext_accum_seq #(.IN_W(4), .SUM_W(6), .BEATS(5), .SIGNED(1), .SATURATE(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(rdy3), .in_data(inData[3][3:0]),
    .in_last(inLast[3]), .out_valid(vld3), .out_ready(outReady[3]), .out_sum(sum3),
    .out_ovf(ovf3), .out_count(cnt3));

  task automatic send_beat(input int k, input logic [14:0] d, input logic last);
    inValid[k] = 1'b1;
    inData[k]  = d;
    inLast[k]  = last;
    @(posedge clk); #1;
    inValid[k] = 1'b0;
    inLast[k]  = 1'b0;
  endtask

  task automatic collect(input int k);
    outReady[k] = 1'b1;
    @(posedge clk); #1;
    outReady[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      inValid[k] = 1'b0; inLast[k] = 1'b0; outReady[k] = 1'b0; inData[k] = '0;
    end
    rst = 1'b1;
    #12;
    checks++; if (vld0 !== 1'b0)     begin errors++; $display("FAIL reset_out_valid got %b want 0", vld0); end
    checks++; if (sum0 !== 17'h0)    begin errors++; $display("FAIL reset_out_sum got %h want 0", sum0); end
    checks++; if (ovf0 !== 1'b0)     begin errors++; $display("FAIL reset_out_ovf got %b want 0", ovf0); end
    checks++; if (cnt0 !== 3'd0)     begin errors++; $display("FAIL reset_out_count got %0d want 0", cnt0); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy0 !== 1'b1)     begin errors++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
    checks++; if (vld3 !== 1'b0)     begin errors++; $display("FAIL reset_out_valid_u3 got %b want 0", vld3); end
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 4; i++) begin
      checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL full_valid_early beat %0d got %b want 0", i, vld0); end
      send_beat(0, 15'h7FFF, 1'b0);
    end
    checks++; if (vld0 !== 1'b1)     begin errors++; $display("FAIL full_latency got %b want 1", vld0); end
    checks++; if (sum0 !== 17'h1FFFC) begin errors++; $display("FAIL full_sum got %h want 1fffc", sum0); end
    checks++; if (ovf0 !== 1'b0)     begin errors++; $display("FAIL full_ovf got %b want 0", ovf0); end
    checks++; if (cnt0 !== 3'd4)     begin errors++; $display("FAIL full_count got %0d want 4", cnt0); end
    collect(0);
    checks++; if (vld0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL full_release valid %b ready %b want 0 1", vld0, rdy0); end
  endtask

  task automatic test_unsigned_modes();
    for (int i = 0; i < 3; i++) send_beat(1, 15'h7FFF, 1'b0);
    checks++; if (vld1 !== 1'b1)     begin errors++; $display("FAIL wrap_valid got %b want 1", vld1); end
    checks++; if (sum1 !== 16'h7FFD) begin errors++; $display("FAIL wrap_sum got %h want 7ffd", sum1); end
    checks++; if (ovf1 !== 1'b1)     begin errors++; $display("FAIL wrap_ovf got %b want 1", ovf1); end
    checks++; if (cnt1 !== 2'd3)     begin errors++; $display("FAIL wrap_count got %0d want 3", cnt1); end
    collect(1);
    for (int i = 0; i < 3; i++) send_beat(2, 15'h7FFF, 1'b0);
    checks++; if (vld2 !== 1'b1)     begin errors++; $display("FAIL sat_valid got %b want 1", vld2); end
    checks++; if (sum2 !== 16'hFFFF) begin errors++; $display("FAIL sat_sum got %h want ffff", sum2); end
    checks++; if (ovf2 !== 1'b1)     begin errors++; $display("FAIL sat_ovf got %b want 1", ovf2); end
    checks++; if (cnt2 !== 2'd3)     begin errors++; $display("FAIL sat_count got %0d want 3", cnt2); end
    collect(2);
  endtask

  task automatic test_signed();
    for (int i = 0; i < 4; i++) send_beat(3, 15'h0008, (i == 3));
    checks++; if (vld3 !== 1'b1)     begin errors++; $display("FAIL sgn4_valid got %b want 1", vld3); end
    checks++; if (sum3 !== 6'h20)    begin errors++; $display("FAIL sgn4_sum got %h want 20", sum3); end
    checks++; if (ovf3 !== 1'b0)     begin errors++; $display("FAIL sgn4_ovf got %b want 0", ovf3); end
    checks++; if (cnt3 !== 3'd4)     begin errors++; $display("FAIL sgn4_count got %0d want 4", cnt3); end
    collect(3);
    for (int i = 0; i < 5; i++) send_beat(3, 15'h0008, 1'b0);
    checks++; if (vld3 !== 1'b1)     begin errors++; $display("FAIL sgn5_valid got %b want 1", vld3); end
    checks++; if (sum3 !== 6'h20)    begin errors++; $display("FAIL sgn5_sum got %h want 20", sum3); end
    checks++; if (ovf3 !== 1'b1)     begin errors++; $display("FAIL sgn5_ovf got %b want 1", ovf3); end
    checks++; if (cnt3 !== 3'd5)     begin errors++; $display("FAIL sgn5_count got %0d want 5", cnt3); end
    collect(3);
  endtask

  task automatic test_early_close();
    send_beat(0, 15'd3, 1'b0);
    send_beat(0, 15'd5, 1'b1);
    checks++; if (vld0 !== 1'b1)     begin errors++; $display("FAIL early_valid got %b want 1", vld0); end
    checks++; if (sum0 !== 17'd8)    begin errors++; $display("FAIL early_sum got %h want 8", sum0); end
    checks++; if (cnt0 !== 3'd2)     begin errors++; $display("FAIL early_count got %0d want 2", cnt0); end
    checks++; if (ovf0 !== 1'b0)     begin errors++; $display("FAIL early_ovf got %b want 0", ovf0); end
    checks++; if (rdy0 !== 1'b0)     begin errors++; $display("FAIL early_in_ready got %b want 0", rdy0); end
    collect(0);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) send_beat(0, 15'(i), 1'b0);
    for (int c = 0; c < 3; c++) begin
      inValid[0] = 1'b1;
      inData[0]  = 15'h1234;
      @(posedge clk); #1;
      checks++; if (vld0 !== 1'b1 || rdy0 !== 1'b0) begin
        errors++; $display("FAIL bp_handshake cyc %0d valid %b ready %b want 1 0", c, vld0, rdy0); end
      checks++; if (sum0 !== 17'd10 || cnt0 !== 3'd4 || ovf0 !== 1'b0) begin
        errors++; $display("FAIL bp_stable cyc %0d sum %h cnt %0d ovf %b want a 4 0", c, sum0, cnt0, ovf0); end
    end
    inValid[0] = 1'b0;
    collect(0);
    send_beat(0, 15'd7, 1'b1);
    checks++; if (vld0 !== 1'b1 || sum0 !== 17'd7 || cnt0 !== 3'd1) begin
      errors++; $display("FAIL bp_next valid %b sum %h cnt %0d want 1 7 1", vld0, sum0, cnt0); end
    collect(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send_beat(0, 15'd1, (i == 3));
    checks++; if (sum0 !== 17'd4 || cnt0 !== 3'd4) begin
      errors++; $display("FAIL b2b_first sum %h cnt %0d want 4 4", sum0, cnt0); end
    collect(0);
    checks++; if (vld0 !== 1'b0)     begin errors++; $display("FAIL b2b_single_end got %b want 0", vld0); end
    send_beat(0, 15'd2, 1'b1);
    checks++; if (vld0 !== 1'b1 || sum0 !== 17'd2 || cnt0 !== 3'd1) begin
      errors++; $display("FAIL b2b_second valid %b sum %h cnt %0d want 1 2 1", vld0, sum0, cnt0); end
    collect(0);
  endtask

  task automatic test_reset_mid_group();
    send_beat(0, 15'h7FFF, 1'b0);
    send_beat(0, 15'h7FFF, 1'b0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid cyc %0d got %b want 0", c, vld0); end
    end
    for (int i = 0; i < 3; i++) send_beat(0, 15'h7FFF, 1'b0);
    checks++; if (vld0 !== 1'b0)     begin errors++; $display("FAIL rstmid_partial got %b want 0", vld0); end
    send_beat(0, 15'h7FFF, 1'b0);
    checks++; if (vld0 !== 1'b1 || sum0 !== 17'h1FFFC || ovf0 !== 1'b0 || cnt0 !== 3'd4) begin
      errors++; $display("FAIL rstmid_group valid %b sum %h ovf %b cnt %0d want 1 1fffc 0 4", vld0, sum0, ovf0, cnt0); end
    collect(0);
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_unsigned_modes();
    test_signed();
    test_early_close();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
